// File: rtl/cam_capture.sv
`default_nettype none
// ============================================================================
//  Module      : cam_capture
//  Description : Captures RGB565 pixels from a DVP-style camera (vsync/href,
//                two bytes per pixel, high byte first), converts them to
//                RGB332 and emits linear, row-major frame-buffer writes.
//                Reports frame completion, buffer overflow and odd-length
//                lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_capture #(
  parameter int AW    = 15,
  parameter int DW    = 8,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          frame_done,
  output logic          ovf,
  output logic          line_err
);

  // Address of the final pixel slot in the frame buffer.
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    BYTE1      = 2'd2,
    BYTE2      = 2'd3
  } state_t;

  state_t        state_q,      state_d;
  logic          vsync_q,      vsync_d;
  logic [AW-1:0] wr_addr_q,    wr_addr_d;
  logic          full_q,       full_d;
  logic [2:0]    red_q,        red_d;
  logic [2:0]    green_q,      green_d;
  logic [AW-1:0] addr_in_q,    addr_in_d;
  logic [DW-1:0] data_in_q,    data_in_d;
  logic          regwrite_q,   regwrite_d;
  logic          frame_done_q, frame_done_d;
  logic          ovf_q,        ovf_d;
  logic          line_err_q,   line_err_d;

  logic          vsync_fall;
  logic          vsync_rise;

  // Edges of vsync relative to the previous sample.
  assign vsync_fall = vsync_q & ~vsync;
  assign vsync_rise = ~vsync_q & vsync;

  // Next-state and output computation; every register holds unless changed.
  always_comb begin
    state_d      = state_q;
    vsync_d      = vsync;
    wr_addr_d    = wr_addr_q;
    full_d       = full_q;
    red_d        = red_q;
    green_d      = green_q;
    addr_in_d    = addr_in_q;
    data_in_d    = data_in_q;
    regwrite_d   = 1'b0;
    frame_done_d = 1'b0;
    ovf_d        = ovf_q;
    line_err_d   = line_err_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = WAIT_FRAME;
        end
      end

      WAIT_FRAME: begin
        // Start of a new frame: rewind the pointer and clear sticky flags.
        if (vsync_fall) begin
          wr_addr_d  = '0;
          full_d     = 1'b0;
          addr_in_d  = '0;
          ovf_d      = 1'b0;
          line_err_d = 1'b0;
          state_d    = BYTE1;
        end
      end

      BYTE1: begin
        // vsync wins over href; a half-received pixel is simply dropped.
        if (vsync_rise) begin
          frame_done_d = 1'b1;
          state_d      = en ? WAIT_FRAME : IDLE;
        end else if (href) begin
          red_d   = px_data[7:5];
          green_d = px_data[2:0];
          state_d = BYTE2;
        end
      end

      BYTE2: begin
        if (vsync_rise) begin
          frame_done_d = 1'b1;
          state_d      = en ? WAIT_FRAME : IDLE;
        end else if (href) begin
          state_d = BYTE1;
          if (full_q) begin
            // Buffer already holds a whole frame: drop the pixel, flag it.
            ovf_d = 1'b1;
          end else begin
            regwrite_d = 1'b1;
            addr_in_d  = wr_addr_q;
            data_in_d  = DW'({red_q, green_q, px_data[4:3]});
            // The pointer parks on the last slot once it has been written.
            if (wr_addr_q == LAST_ADDR) begin
              full_d = 1'b1;
            end else begin
              wr_addr_d = wr_addr_q + AW'(1);
            end
          end
        end else begin
          // href dropped between the two bytes of a pixel.
          line_err_d = 1'b1;
          state_d    = BYTE1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b0;
      wr_addr_q    <= '0;
      full_q       <= 1'b0;
      red_q        <= '0;
      green_q      <= '0;
      addr_in_q    <= '0;
      data_in_q    <= '0;
      regwrite_q   <= 1'b0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      wr_addr_q    <= wr_addr_d;
      full_q       <= full_d;
      red_q        <= red_d;
      green_q      <= green_d;
      addr_in_q    <= addr_in_d;
      data_in_q    <= data_in_d;
      regwrite_q   <= regwrite_d;
      frame_done_q <= frame_done_d;
      ovf_q        <= ovf_d;
      line_err_q   <= line_err_d;
    end
  end

  assign addr_in    = addr_in_q;
  assign data_in    = data_in_q;
  assign regwrite   = regwrite_q;
  assign frame_done = frame_done_q;
  assign ovf        = ovf_q;
  assign line_err   = line_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cam_capture
//  Description : Self-checking bench for cam_capture. Frames are described
//                as lists of line byte counts; a frame-level model derives
//                the expected write list and flags from the pixel rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_capture;

  localparam int AW    = 15;
  localparam int DW    = 8;
  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int NPIX  = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          regwrite;
  logic          frame_done;
  logic          ovf;
  logic          line_err;

  cam_capture #(
    .AW    (AW),
    .DW    (DW),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .vsync      (vsync),
    .href       (href),
    .px_data    (px_data),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .regwrite   (regwrite),
    .frame_done (frame_done),
    .ovf        (ovf),
    .line_err   (line_err)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_errors  = 0;
  int act_q[$];          // observed writes, packed as (addr << 8) | data
  int exp_q[$];          // expected writes, same packing
  int line_q[$];         // byte count of each line in the next frame
  int fd_cnt    = 0;     // cycles with frame_done high
  int byte_mode = 0;     // 0 random, 1 all 0xFF, 2 alternating 0xF8/0x1F
  int pend_full = 0;
  bit ovf_exp;
  bit lerr_exp;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Collect every write and every frame_done cycle.
  always @(negedge clk) begin
    if (regwrite === 1'b1) act_q.push_back((int'(addr_in) << 8) | int'(data_in));
    if (frame_done === 1'b1) fd_cnt++;
  end

  function automatic logic [7:0] next_byte(input int idx);
    case (byte_mode)
      1:       return 8'hFF;
      2:       return idx[0] ? 8'h1F : 8'hF8;
      default: return 8'($urandom);
    endcase
  endfunction

  // One clock of stimulus; also checks the buffer-just-full condition.
  task automatic drive(input logic v, input logic h, input logic [7:0] d);
    @(negedge clk);
    if (pend_full == 1) begin
      check("ovf_at_full", ovf, 0);
      check("addr_at_full", addr_in, NPIX - 1);
      pend_full = 0;
    end
    vsync   = v;
    href    = h;
    px_data = d;
  endtask

  // Send one frame built from line_q, then compare against the model.
  task automatic send_frame(input int gap_max, input bit abrupt);
    int         pix;
    int         fd0;
    int         n;
    int         err0;
    bit         last;
    logic [7:0] hi;
    logic [7:0] d;
    pix      = 0;
    hi       = 8'h00;
    ovf_exp  = 1'b0;
    lerr_exp = 1'b0;
    exp_q.delete();
    fd0 = fd_cnt;
    drive(1, 0, 0);
    drive(1, 0, 0);
    act_q.delete();
    drive(0, 0, 0);
    drive(0, 0, 0);
    foreach (line_q[l]) begin
      for (int b = 0; b < line_q[l]; b++) begin
        d = next_byte(b);
        drive(0, 1, d);
        if (b % 2 == 0) begin
          hi = d;
        end else begin
          if (pix < NPIX) begin
            exp_q.push_back((pix << 8) | int'({hi[7:5], hi[2:0], d[4:3]}));
            if (pix == NPIX - 1) pend_full = 1;
          end else begin
            ovf_exp = 1'b1;
          end
          pix++;
        end
      end
      last = (l == line_q.size() - 1);
      if (!(abrupt && last)) begin
        if (line_q[l] % 2 == 1) lerr_exp = 1'b1;
        for (int g = 0; g < gap_max; g++) drive(0, 0, 0);
      end
    end
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    check("frame_done_pulses", fd_cnt - fd0, 1);
    check("write_count", act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    err0 = n_errors;
    for (int i = 0; i < n; i++) begin
      check("write_addr_data", act_q[i], exp_q[i]);
      if (n_errors != err0) break;
    end
    check("ovf", ovf, ovf_exp);
    check("line_err", line_err, lerr_exp);
    if (ovf_exp) check("addr_held", addr_in, NPIX - 1);
  endtask

  initial begin
    int fd0;
    int nl;
    rst     = 1'b1;
    en      = 1'b0;
    vsync   = 1'b0;
    href    = 1'b0;
    px_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_addr_in", addr_in, 0);
    check("rst_data_in", data_in, 0);
    check("rst_regwrite", regwrite, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_line_err", line_err, 0);
    rst = 1'b0;
    en  = 1'b1;

    // Single pixel 0xF8,0x1F -> RGB332 0xE3 at address 0.
    byte_mode = 2;
    line_q = '{2};
    send_frame(1, 1'b0);
    check("first_px_data", (act_q.size() > 0) ? (act_q[0] & 255) : -1, 'hE3);
    check("first_px_addr", (act_q.size() > 0) ? (act_q[0] >> 8) : -1, 0);

    // Odd line then a new line: line_err, second pixel at address 1.
    byte_mode = 0;
    line_q = '{3, 2};
    send_frame(2, 1'b0);
    check("next_line_addr", (act_q.size() > 1) ? (act_q[1] >> 8) : -1, 1);

    // vsync rises right after the first byte: no write, no line_err.
    line_q = '{1};
    send_frame(1, 1'b1);

    // Randomized frames with odd/even lines, gaps and abrupt ends.
    repeat (10) begin
      line_q.delete();
      nl = $urandom_range(1, 5);
      repeat (nl) line_q.push_back($urandom_range(0, 24));
      send_frame($urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end

    // en low at frame end: falls back to IDLE and ignores the next frame.
    en = 1'b0;
    line_q = '{4};
    send_frame(1, 1'b0);
    act_q.delete();
    fd0 = fd_cnt;
    drive(0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 8'($urandom));
    drive(1, 0, 0);
    drive(1, 0, 0);
    check("idle_no_writes", act_q.size(), 0);
    check("idle_no_frame_done", fd_cnt - fd0, 0);
    en = 1'b1;

    // Reset after 50 pixels aborts the frame silently.
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(0, 0, 0);
    act_q.delete();
    fd0 = fd_cnt;
    for (int i = 0; i < 100; i++) drive(0, 1, 8'($urandom));
    @(negedge clk);
    rst     = 1'b1;
    px_data = 8'($urandom);
    @(negedge clk);
    check("mid_rst_writes", act_q.size(), 50);
    check("mid_rst_addr_in", addr_in, 0);
    check("mid_rst_data_in", data_in, 0);
    check("mid_rst_regwrite", regwrite, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_line_err", line_err, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) drive(0, 1, 8'($urandom));
    drive(1, 0, 0);
    drive(1, 0, 0);
    check("post_rst_writes", act_q.size(), 50);
    check("post_rst_frame_done", fd_cnt - fd0, 0);

    // Recovery frame after reset.
    line_q = '{6, 5};
    send_frame(2, 1'b0);

    // Full frame of 0xFF plus one extra pixel: 19200 writes, then overflow.
    byte_mode = 1;
    line_q.delete();
    repeat (IMG_H) line_q.push_back(2 * IMG_W);
    line_q.push_back(2);
    send_frame(1, 1'b0);
    check("full_last_addr", (act_q.size() > 0) ? (act_q[act_q.size()-1] >> 8) : -1, 'h4AFF);
    check("full_last_data", (act_q.size() > 0) ? (act_q[act_q.size()-1] & 255) : -1, 'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
